// File: rtl/pi_fifo_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : pi_fifo_link_ctrl
//  Purpose : Pi-side sequencer for the dual 40105 FIFO link; drains the
//            host->slave FIFO and fills the slave->host FIFO over shared sd.
//  Rev     : 1.0  initial release
// ============================================================================
module pi_fifo_link_ctrl #(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int SETUP_CYCLES   = 2,
  parameter int PULSE_CYCLES   = 2,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             fifo_slave_dor,
  input  logic             fifo_slave_dir,
  output logic             slave_fifo_sob,
  output logic             slave_fifo_oeb,
  output logic             slave_fifo_si,
  output logic             bus_wnr,
  input  logic [WIDTH-1:0] sd_in,
  output logic [WIDTH-1:0] sd_out,
  output logic             sd_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready
);

  localparam int c_MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int c_MAX_CYC = (c_MAX_SP > RECOVER_CYCLES) ? c_MAX_SP : RECOVER_CYCLES;
  localparam int c_TW      = $clog2(c_MAX_CYC) + 1;

  localparam logic [c_TW-1:0] c_LOAD_SETUP   = c_TW'(SETUP_CYCLES - 1);
  localparam logic [c_TW-1:0] c_LOAD_PULSE   = c_TW'(PULSE_CYCLES - 1);
  localparam logic [c_TW-1:0] c_LOAD_RECOVER = c_TW'(RECOVER_CYCLES - 1);
  localparam logic [c_TW-1:0] c_ZERO         = '0;
  localparam logic [c_TW-1:0] c_ONE          = c_TW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SETUP, S_RD_SO, S_RD_RECOVER,
    S_WR_SETUP, S_WR_SI, S_WR_HOLD, S_WR_RECOVER
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_dor_sync;
  logic [SYNC_STAGES-1:0] r_dir_sync;
  logic [c_TW-1:0]        r_timer;
  logic [c_TW-1:0]        w_timer_load;
  logic                   w_timer_done;
  logic                   r_last_grant_wr;
  logic                   w_dor_s;
  logic                   w_dir_s;
  logic                   w_rd_req;
  logic                   w_wr_req;
  logic                   w_grant_rd;
  logic                   w_grant_wr;
  logic                   w_drive_next;
  logic                   r_sob;
  logic                   r_oeb;
  logic                   r_si;
  logic                   r_drive;
  logic [WIDTH-1:0]       r_sd_out;
  logic [WIDTH-1:0]       r_rx_data;
  logic                   r_rx_valid;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_dor_sync <= '0;
      r_dir_sync <= '0;
    end else begin
      r_dor_sync <= {r_dor_sync[SYNC_STAGES-2:0], fifo_slave_dor};
      r_dir_sync <= {r_dir_sync[SYNC_STAGES-2:0], fifo_slave_dir};
    end
  end

  assign w_dor_s      = r_dor_sync[SYNC_STAGES-1];
  assign w_dir_s      = r_dir_sync[SYNC_STAGES-1];
  assign w_rd_req     = w_dor_s & ~r_rx_valid;
  assign w_wr_req     = w_dir_s & tx_valid;
  assign w_timer_done = (r_timer == c_ZERO);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_rd   = 1'b0;
    w_grant_wr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rd_req && w_wr_req) begin
          w_grant_rd = r_last_grant_wr;
          w_grant_wr = ~r_last_grant_wr;
        end else begin
          w_grant_rd = w_rd_req;
          w_grant_wr = w_wr_req;
        end
        if (w_grant_rd)      w_state_next = S_RD_SETUP;
        else if (w_grant_wr) w_state_next = S_WR_SETUP;
      end
      S_RD_SETUP:   if (w_timer_done) w_state_next = S_RD_SO;
      S_RD_SO:      if (w_timer_done) w_state_next = S_RD_RECOVER;
      S_RD_RECOVER: if (w_timer_done) w_state_next = S_IDLE;
      S_WR_SETUP:   if (w_timer_done) w_state_next = S_WR_SI;
      S_WR_SI:      if (w_timer_done) w_state_next = S_WR_HOLD;
      S_WR_HOLD:    w_state_next = S_WR_RECOVER;
      S_WR_RECOVER: if (w_timer_done) w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_timer_load = c_ZERO;
    case (w_state_next)
      S_RD_SETUP, S_WR_SETUP:     w_timer_load = c_LOAD_SETUP;
      S_RD_SO, S_WR_SI:           w_timer_load = c_LOAD_PULSE;
      S_RD_RECOVER, S_WR_RECOVER: w_timer_load = c_LOAD_RECOVER;
      default:                    w_timer_load = c_ZERO;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_timer <= c_ZERO;
    end else if (w_state_next != r_state) begin
      r_timer <= w_timer_load;
    end else if (!w_timer_done) begin
      r_timer <= r_timer - c_ONE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_last_grant_wr <= 1'b1;
    end else if (w_grant_rd) begin
      r_last_grant_wr <= 1'b0;
    end else if (w_grant_wr) begin
      r_last_grant_wr <= 1'b1;
    end
  end

  // Strobes are registered from the next state so the pads never see decode glitches.
  assign w_drive_next = (w_state_next == S_WR_SETUP) || (w_state_next == S_WR_SI) ||
                        (w_state_next == S_WR_HOLD);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sob   <= 1'b1;
      r_oeb   <= 1'b1;
      r_si    <= 1'b0;
      r_drive <= 1'b0;
    end else begin
      r_sob   <= (w_state_next != S_RD_SO);
      r_oeb   <= !((w_state_next == S_RD_SETUP) || (w_state_next == S_RD_SO));
      r_si    <= (w_state_next == S_WR_SI);
      r_drive <= w_drive_next;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sd_out <= '0;
    end else if (w_grant_wr) begin
      r_sd_out <= tx_data;
    end
  end

  // Capture at the end of the first SO cycle: the bus has then been stable SETUP_CYCLES+1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if ((r_state == S_RD_SO) && (r_timer == c_LOAD_PULSE)) begin
      r_rx_data  <= sd_in;
      r_rx_valid <= 1'b1;
    end else if (r_rx_valid && rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign slave_fifo_sob = r_sob;
  assign slave_fifo_oeb = r_oeb;
  assign slave_fifo_si  = r_si;
  assign bus_wnr        = r_drive;
  assign sd_oe          = r_drive;
  assign sd_out         = r_sd_out;
  assign tx_ready       = w_grant_wr;
  assign rx_data        = r_rx_data;
  assign rx_valid       = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_pi_fifo_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pi_fifo_link_ctrl
//  Purpose : Self-checking bench for pi_fifo_link_ctrl with simple FIFO models.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pi_fifo_link_ctrl;

  localparam int SYNC_STAGES = 2;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       dor, dir;
  logic       sob, oeb, si, wnr, sd_oe;
  logic [7:0] sd_in, sd_out;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;

  int checks = 0;
  int errors = 0;

  // host->slave FIFO model: tasks own the write side, the SOB monitor the read side
  logic [7:0] hmem [0:15];
  logic [7:0] hw = 8'd0;
  logic [7:0] hr = 8'd0;
  assign dor   = (hw != hr);
  assign sd_in = hmem[hr[3:0]];

  logic [7:0] smem [0:15];
  logic [7:0] rmem [0:15];
  logic       gmem [0:63];
  int sw = 0, rw = 0, gw = 0, si_cnt = 0, sob_falls = 0, viol = 0;
  int s_rd = 0, r_rd = 0;
  logic p_rst = 1'b1, p_oeb = 1'b1, p_sob = 1'b1, p_wnr = 1'b0, p_oe = 1'b0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  always #5 CLK = ~CLK;

  pi_fifo_link_ctrl #(
    .WIDTH(8), .SYNC_STAGES(SYNC_STAGES), .SETUP_CYCLES(2),
    .PULSE_CYCLES(2), .RECOVER_CYCLES(4)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .fifo_slave_dor(dor), .fifo_slave_dir(dir),
    .slave_fifo_sob(sob), .slave_fifo_oeb(oeb), .slave_fifo_si(si),
    .bus_wnr(wnr), .sd_in(sd_in), .sd_out(sd_out), .sd_oe(sd_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always @(posedge sob) begin
    if (!RESET && dor) hr <= hr + 8'd1;
  end

  always @(posedge si) begin
    if (!RESET) begin
      smem[sw[3:0]] <= sd_out;
      sw     <= sw + 1;
      si_cnt <= si_cnt + 1;
    end
  end

  // Bus-safety / stale-read watch, rx collector and grant log
  always @(negedge CLK) begin
    if (!RESET && !p_rst) begin
      if (!oeb && sd_oe) begin
        $display("FAIL bus_contention: oeb=%b sd_oe=%b required not both active", oeb, sd_oe);
        viol <= viol + 1;
      end
      if (wnr !== p_wnr && !(oeb && p_oeb && (wnr ? !p_oe : !sd_oe))) begin
        $display("FAIL wnr_change: wnr %b->%b with oeb=%b sd_oe=%b", p_wnr, wnr, oeb, sd_oe);
        viol <= viol + 1;
      end
      if (!sob && p_sob) begin
        sob_falls <= sob_falls + 1;
        if (!dor) begin
          $display("FAIL stale_read: sob fell with dor=%b required 1", dor);
          viol <= viol + 1;
        end
      end
      if (rx_valid && rx_ready) begin
        rmem[rw[3:0]] <= rx_data;
        rw <= rw + 1;
      end
      if (tx_ready) begin
        gmem[gw[5:0]] <= 1'b1;
        gw <= gw + 1;
      end else if (!oeb && p_oeb) begin
        gmem[gw[5:0]] <= 1'b0;
        gw <= gw + 1;
      end
    end
    p_rst <= RESET;
    p_oeb <= oeb;
    p_sob <= sob;
    p_wnr <= wnr;
    p_oe  <= sd_oe;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_host(input logic [7:0] b);
    hmem[hw[3:0]] = b;
    hw = hw + 8'd1;
    rx_exp.push_back(b);
  endtask

  task automatic send_tx(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      int waited = 0;
      tx_data  = first + 8'(i);
      tx_valid = 1'b1;
      tx_exp.push_back(tx_data);
      do begin
        @(negedge CLK);
        waited++;
      end while (!tx_ready && waited < 300);
      if (!tx_ready) begin
        errors++;
        $display("FAIL tx_accept_timeout: byte %0h not accepted, tx_ready=%b required 1", tx_data, tx_ready);
      end
      tick();
    end
    tx_valid = 1'b0;
  endtask

  task automatic drain_rx_check(input string tag);
    while (rx_exp.size() > 0) begin
      logic [7:0] e;
      e = rx_exp.pop_front();
      checks++;
      if (r_rd >= rw) begin
        errors++;
        $display("FAIL %s_rx_missing: got nothing required %0h", tag, e);
      end else begin
        if (rmem[r_rd[3:0]] !== e) begin
          errors++;
          $display("FAIL %s_rx_data: got %0h required %0h", tag, rmem[r_rd[3:0]], e);
        end
        r_rd++;
      end
    end
  endtask

  task automatic drain_tx_check(input string tag);
    while (tx_exp.size() > 0) begin
      logic [7:0] e;
      e = tx_exp.pop_front();
      checks++;
      if (s_rd >= sw) begin
        errors++;
        $display("FAIL %s_tx_missing: got nothing required %0h", tag, e);
      end else begin
        if (smem[s_rd[3:0]] !== e) begin
          errors++;
          $display("FAIL %s_tx_data: got %0h required %0h", tag, smem[s_rd[3:0]], e);
        end
        s_rd++;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; dir = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({sob, oeb, si, wnr, sd_oe} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 11000", {sob, oeb, si, wnr, sd_oe});
    end
    checks++;
    if (sd_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_sd_out: got %0h required 0", sd_out);
    end
    checks++;
    if ({rx_valid, rx_data} !== 9'h000) begin
      errors++;
      $display("FAIL reset_rx: got valid=%b data=%0h required 0/0", rx_valid, rx_data);
    end
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx_ready: got %b required 0", tx_ready);
    end
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    dir = 1'b1; tx_data = 8'h77; tx_valid = 1'b1;
    tx_exp.push_back(8'h77);
    do begin
      @(negedge CLK);
      n++;
    end while (!si && n < 40);
    tx_valid = 1'b0;
    checks++;
    if (!(si && sd_oe)) begin
      errors++;
      $display("FAIL mid_reach_si: got si=%b sd_oe=%b required 1/1", si, sd_oe);
    end
    #2 RESET = 1'b1;
    dir = 1'b0;
    @(negedge CLK);
    checks++;
    if ({si, sd_oe, sob, oeb, wnr} !== 5'b00110) begin
      errors++;
      $display("FAIL mid_reset_strobes: got %b required 00110", {si, sd_oe, sob, oeb, wnr});
    end
    checks++;
    if (rx_valid !== 1'b0 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hs: got rx_valid=%b tx_ready=%b required 0/0", rx_valid, tx_ready);
    end
    tick();
    RESET = 1'b0;
    drain_tx_check("mid");
    repeat (3) tick();
  endtask

  task automatic test_read();
    logic s_sob[0:19], s_oeb[0:19], s_rxv[0:19];
    int first = -1, sob_lo = 0, oeb_lo = 0, rxv = 0;
    rx_ready = 1'b1;
    tick();
    push_host(8'hA5);
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      s_sob[k] = sob; s_oeb[k] = oeb; s_rxv[k] = rx_valid;
    end
    for (int k = 0; k < 20; k++) begin
      if (!s_sob[k]) sob_lo++;
      if (!s_oeb[k]) oeb_lo++;
      if (s_rxv[k]) begin
        rxv++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (first != SYNC_STAGES + 1 + 2 + 1) begin
      errors++;
      $display("FAIL read_latency: got %0d required %0d", first, SYNC_STAGES + 4);
    end
    checks++;
    if (sob_lo != 2) begin
      errors++;
      $display("FAIL read_sob_width: got %0d required 2", sob_lo);
    end
    checks++;
    if (oeb_lo != 4) begin
      errors++;
      $display("FAIL read_oeb_width: got %0d required 4", oeb_lo);
    end
    checks++;
    if (rxv != 1) begin
      errors++;
      $display("FAIL read_rx_valid_cycles: got %0d required 1", rxv);
    end
    drain_rx_check("read");
  endtask

  task automatic test_write();
    logic a_si[0:19], a_oe[0:19], a_wnr[0:19], a_txr[0:19];
    logic [7:0] a_sd[0:19];
    int txr = 0, sih = 0, fs = -1;
    dir = 1'b1;
    repeat (4) tick();
    tx_data = 8'h3C; tx_valid = 1'b1;
    tx_exp.push_back(8'h3C);
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      a_si[k] = si; a_oe[k] = sd_oe; a_wnr[k] = wnr; a_txr[k] = tx_ready; a_sd[k] = sd_out;
      if (tx_ready) begin
        tick();
        tx_valid = 1'b0;
      end
    end
    for (int k = 0; k < 20; k++) begin
      if (a_txr[k]) txr++;
      if (a_si[k]) begin
        sih++;
        if (fs < 0) fs = k;
      end
    end
    checks++;
    if (txr != 1) begin
      errors++;
      $display("FAIL write_tx_ready_cycles: got %0d required 1", txr);
    end
    checks++;
    if (sih != 2) begin
      errors++;
      $display("FAIL write_si_width: got %0d required 2", sih);
    end
    checks++;
    if (fs != 3) begin
      errors++;
      $display("FAIL write_si_start: got %0d required 3", fs);
    end else begin
      checks++;
      if (!(a_wnr[2] && a_oe[2] && a_sd[2] === 8'h3C)) begin
        errors++;
        $display("FAIL write_setup_bus: got wnr=%b oe=%b sd=%0h required 1/1/3c", a_wnr[2], a_oe[2], a_sd[2]);
      end
      checks++;
      if (!(!a_si[5] && a_oe[5] && a_sd[5] === 8'h3C && !a_oe[6])) begin
        errors++;
        $display("FAIL write_hold: got si=%b oe=%b sd=%0h oe_next=%b required 0/1/3c/0", a_si[5], a_oe[5], a_sd[5], a_oe[6]);
      end
    end
    drain_tx_check("write");
  endtask

  task automatic test_dir_gate();
    int txr = 0, si0, first = -1;
    dir = 1'b0;
    repeat (4) tick();
    si0 = si_cnt;
    tx_data = 8'h5A; tx_valid = 1'b1;
    tx_exp.push_back(8'h5A);
    repeat (12) begin
      @(negedge CLK);
      if (tx_ready) txr++;
    end
    checks++;
    if (txr != 0 || si_cnt != si0) begin
      errors++;
      $display("FAIL gate_no_dir: got tx_ready=%0d si=%0d required 0/0", txr, si_cnt - si0);
    end
    tick();
    dir = 1'b1;
    for (int k = 0; k < 30 && first < 0; k++) begin
      @(negedge CLK);
      if (tx_ready) first = k;
    end
    // accepted on the edge after this sample, SYNC_STAGES+1 edges after DIR rose
    checks++;
    if (first != SYNC_STAGES) begin
      errors++;
      $display("FAIL gate_dir_latency: got %0d required %0d", first, SYNC_STAGES);
    end
    tick();
    tx_valid = 1'b0;
    repeat (15) tick();
    drain_tx_check("gate");
  endtask

  task automatic test_back_to_back();
    int g0, n = 0;
    rx_ready = 1'b1;
    dir = 1'b1;
    g0 = gw;
    for (int i = 0; i < 4; i++) push_host(8'h90 + 8'(i));
    fork
      send_tx(8'h01, 4);
      begin
        while (gw - g0 < 8 && n < 300) begin
          @(negedge CLK);
          n++;
        end
      end
    join
    repeat (12) tick();
    checks++;
    if (gw - g0 != 8) begin
      errors++;
      $display("FAIL rr_grant_count: got %0d required 8", gw - g0);
    end else begin
      checks++;
      if (gmem[g0[5:0]] !== 1'b1) begin
        errors++;
        $display("FAIL rr_first_grant: got %b required 1 (WR)", gmem[g0[5:0]]);
      end
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (gmem[6'(g0 + i)] === gmem[6'(g0 + i - 1)]) begin
          errors++;
          $display("FAIL rr_alternate: grant %0d got %b required %b", i, gmem[6'(g0 + i)], ~gmem[6'(g0 + i - 1)]);
        end
      end
    end
    drain_rx_check("rr");
    drain_tx_check("rr");
  endtask

  task automatic test_rx_backpressure();
    int sob0, si0;
    rx_ready = 1'b0;
    dir = 1'b1;
    sob0 = sob_falls;
    si0  = si_cnt;
    push_host(8'hC1); push_host(8'hC2); push_host(8'hC3);
    fork
      send_tx(8'hE1, 2);
      repeat (80) @(negedge CLK);
    join
    checks++;
    if (sob_falls - sob0 != 1) begin
      errors++;
      $display("FAIL bp_sob_blocked: got %0d pulses required 1", sob_falls - sob0);
    end
    checks++;
    if (si_cnt - si0 != 2) begin
      errors++;
      $display("FAIL bp_tx_continue: got %0d si pulses required 2", si_cnt - si0);
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== rx_exp[0]) begin
      errors++;
      $display("FAIL bp_rx_hold: got valid=%b data=%0h required 1/%0h", rx_valid, rx_data, rx_exp[0]);
    end
    tick();
    rx_ready = 1'b1;
    repeat (60) tick();
    checks++;
    if (sob_falls - sob0 != 3) begin
      errors++;
      $display("FAIL bp_resume: got %0d pulses required 3", sob_falls - sob0);
    end
    drain_rx_check("bp");
    drain_tx_check("bp");
  endtask

  task automatic test_bus_safety();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL bus_safety: got %0d violations required 0", viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) hmem[i] = 8'h00;
    test_reset();
    test_reset_mid();
    test_read();
    test_write();
    test_dir_gate();
    test_back_to_back();
    test_rx_backpressure();
    test_bus_safety();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
